// File: rtl/bus_pkg.sv
// Shared definitions for the synth register bus.
// Contents: bus widths, BusReadWrite encodings and the initiator state enum.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        HOLD
    } bus_state_e;

endpackage

// File: rtl/bus_phase_timer.sv
// Phase timer for the bus initiator: counts Clock cycles within one bus phase.
// Ports:
//   Clock      in   system clock
//   Reset      in   synchronous active-high reset
//   load       in   restart the count at zero (start of a new phase)
//   run        in   advance the count this cycle
//   phase_done out  high on the last Clock cycle of the current phase
module bus_phase_timer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic load,
    input  logic run,
    output logic phase_done
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] count_q;

    // Every phase ends with a reload, so the count never passes CLK_DIV-1.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign phase_done = (count_q == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/bus_master.sv
// Initiator for the synth register bus. Takes one host read/write at a time, runs it as
// SETUP / HIGH / HOLD phases of CLK_DIV cycles each and returns read data.
// Ports:
//   Clock, Reset        system clock, synchronous active-high reset
//   ReqValid/ReqReady   host request handshake (ReqReady high only in IDLE)
//   ReqWrite            1 = write, 0 = read
//   ReqAddress/ReqData  request address and write data
//   RspValid/RspData    one-cycle read-complete pulse and held read data
//   Busy                inverse of ReqReady
//   BusAddress          bus address, holds last value between transactions
//   BusData             bidirectional data, driven only during writes
//   BusReadWrite        1 = write, 0 = read; idles at 1
//   BusClock            strobe, one rising edge per transaction
module bus_master
    import bus_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [BUS_ADDR_W-1:0] ReqAddress,
    input  logic [BUS_DATA_W-1:0] ReqData,
    output logic                  RspValid,
    output logic [BUS_DATA_W-1:0] RspData,
    output logic                  Busy,
    output logic [BUS_ADDR_W-1:0] BusAddress,
    inout  wire  [BUS_DATA_W-1:0] BusData,
    output logic                  BusReadWrite,
    output logic                  BusClock
);

    bus_state_e state_q, state_d;

    logic [BUS_ADDR_W-1:0] addr_q;
    logic [BUS_DATA_W-1:0] wdata_q;
    logic [BUS_DATA_W-1:0] rsp_data_q;
    logic                  rw_q;
    logic                  clk_q;
    logic                  rsp_valid_q;
    logic                  phase_done;
    logic                  accept;
    logic                  load;

    assign accept = ReqValid && (state_q == IDLE);
    assign load   = accept || ((state_q != IDLE) && phase_done);

    bus_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_timer (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (load),
        .run       (state_q != IDLE),
        .phase_done(phase_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ReqValid)   state_d = SETUP;
            SETUP:   if (phase_done) state_d = HIGH;
            HIGH:    if (phase_done) state_d = HOLD;
            HOLD:    if (phase_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= RW_WRITE;
            clk_q       <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Registered strobe keeps BusClock glitch-free.
            clk_q       <= (state_d == HIGH);
            rsp_valid_q <= 1'b0;
            if (accept) begin
                addr_q  <= ReqAddress;
                rw_q    <= ReqWrite;
                wdata_q <= ReqData;
            end
            // Sample on the last HIGH cycle: responders registered data a cycle or more ago.
            if ((state_q == HIGH) && phase_done && (rw_q == RW_READ)) begin
                rsp_data_q  <= BusData;
                rsp_valid_q <= 1'b1;
            end
            // Back to write polarity in IDLE so responders release BusData.
            if ((state_q == HOLD) && phase_done) begin
                rw_q <= RW_WRITE;
            end
        end
    end

    assign BusData      = ((state_q != IDLE) && (rw_q == RW_WRITE)) ? wdata_q
                                                                    : {BUS_DATA_W{1'bz}};
    assign ReqReady     = (state_q == IDLE);
    assign Busy         = (state_q != IDLE);
    assign BusAddress   = addr_q;
    assign BusReadWrite = rw_q;
    assign BusClock     = clk_q;
    assign RspValid     = rsp_valid_q;
    assign RspData      = rsp_data_q;

endmodule

// File: tb/tb_bus_master.sv
module tb_bus_master;

    localparam int D0 = 2;
    localparam int D1 = 4;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    logic        req_valid   [2] = '{1'b0, 1'b0};
    logic        req_write   [2] = '{1'b0, 1'b0};
    logic [15:0] req_address [2] = '{16'h0, 16'h0};
    logic [7:0]  req_data    [2] = '{8'h0, 8'h0};
    logic        req_ready   [2];
    logic        rsp_valid   [2];
    logic        busy        [2];
    logic        bus_rw      [2];
    logic        bus_clk     [2];
    logic [7:0]  rsp_data    [2];
    logic [15:0] bus_addr    [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic hit(input logic [15:0] a);
        return (a >= 16'h0010) && (a <= 16'h0013);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D = (g == 0) ? D0 : D1;
        wire [7:0] bd;
        pullup (bd);

        bus_master #(
            .CLK_DIV(D)
        ) dut (
            .Clock       (Clock),
            .Reset       (Reset),
            .ReqValid    (req_valid[g]),
            .ReqReady    (req_ready[g]),
            .ReqWrite    (req_write[g]),
            .ReqAddress  (req_address[g]),
            .ReqData     (req_data[g]),
            .RspValid    (rsp_valid[g]),
            .RspData     (rsp_data[g]),
            .Busy        (busy[g]),
            .BusAddress  (bus_addr[g]),
            .BusData     (bd),
            .BusReadWrite(bus_rw[g]),
            .BusClock    (bus_clk[g])
        );

        // Responder: wave generator controller with four registers at 0x0010..0x0013.
        logic [7:0] regs [4] = '{default: 8'h00};
        logic [7:0] rd_q     = 8'h00;
        logic       rd_oe    = 1'b0;
        logic       clk_prev = 1'b0;

        always @(posedge Clock) begin
            clk_prev <= bus_clk[g];
            if (bus_rw[g]) rd_oe <= 1'b0;
            if (bus_clk[g] && !clk_prev && hit(bus_addr[g])) begin
                if (bus_rw[g]) begin
                    regs[bus_addr[g][1:0]] <= bd;
                end else begin
                    rd_q  <= regs[bus_addr[g][1:0]];
                    rd_oe <= 1'b1;
                end
            end
        end

        assign bd = (rd_oe && !bus_rw[g]) ? rd_q : 8'hzz;

        // Model: p = cycles since accept; phases are D cycles each, 3*D in total.
        logic        m_busy = 1'b0;
        logic        m_wr   = 1'b0;
        int          m_p    = 0;
        logic [15:0] m_addr = 16'h0;
        logic [7:0]  m_data = 8'h0;
        logic [7:0]  m_rsp  = 8'h0;
        logic [7:0]  m_mem [4] = '{default: 8'h00};

        always @(posedge Clock) begin
            if (Reset) begin
                m_busy <= 1'b0;
                m_p    <= 0;
                m_addr <= 16'h0;
                m_rsp  <= 8'h0;
            end else if (!m_busy) begin
                if (req_valid[g]) begin
                    m_busy <= 1'b1;
                    m_p    <= 0;
                    m_wr   <= req_write[g];
                    m_addr <= req_address[g];
                    m_data <= req_data[g];
                end
            end else begin
                m_p <= m_p + 1;
                if (m_p == 3 * D - 1) m_busy <= 1'b0;
                if (m_p == D && m_wr && hit(m_addr)) m_mem[m_addr[1:0]] <= m_data;
                if (m_p == 2 * D - 1 && !m_wr)
                    m_rsp <= hit(m_addr) ? m_mem[m_addr[1:0]] : 8'hFF;
            end
        end

        initial begin
            forever begin
                @(negedge Clock);
                if (chk_en) begin
                    check("ReqReady", req_ready[g], !m_busy);
                    check("Busy", busy[g], m_busy);
                    check("BusClock", bus_clk[g], m_busy && m_p >= D && m_p < 2 * D);
                    check("BusReadWrite", bus_rw[g], m_busy ? m_wr : 1'b1);
                    check("BusAddress", bus_addr[g], m_addr);
                    check("RspValid", rsp_valid[g], m_busy && !m_wr && m_p == 2 * D);
                    check("RspData", rsp_data[g], m_rsp);
                    if (m_busy && m_wr) check("BusData write", bd, m_data);
                    if (m_busy && !m_wr && !hit(m_addr)) check("BusData float", bd, 8'hFF);
                end
            end
        end
    end

    // Observers used by the literal checks.
    int rise_q[$];
    int lo_rdy[2]      = '{0, 0};
    int last_lo_rdy[2] = '{0, 0};
    int hi_len[2]      = '{0, 0};
    int last_hi_len[2] = '{0, 0};
    int rv_cnt[2]      = '{0, 0};

    initial begin
        logic [1:0] prev;
        prev = 2'b00;
        forever begin
            @(negedge Clock);
            for (int i = 0; i < 2; i++) begin
                if (i == 0 && bus_clk[i] && !prev[i]) rise_q.push_back(cyc);
                prev[i] = bus_clk[i];
                if (!req_ready[i]) lo_rdy[i]++;
                else if (lo_rdy[i] != 0) begin
                    last_lo_rdy[i] = lo_rdy[i];
                    lo_rdy[i] = 0;
                end
                if (bus_clk[i]) hi_len[i]++;
                else if (hi_len[i] != 0) begin
                    last_hi_len[i] = hi_len[i];
                    hi_len[i] = 0;
                end
                if (rsp_valid[i]) rv_cnt[i]++;
            end
        end
    end

    task automatic do_req(input int g, input logic wr, input logic [15:0] a, input logic [7:0] d);
        logic ok;
        int n;
        n = 0;
        req_valid[g]   = 1'b1;
        req_write[g]   = wr;
        req_address[g] = a;
        req_data[g]    = d;
        forever begin
            @(negedge Clock);
            ok = req_ready[g];
            @(posedge Clock);
            #1;
            if (ok) break;
            n++;
            if (n > 100) begin
                check("accept timeout", 32'd0, 32'd1);
                break;
            end
        end
        req_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!req_ready[g] && n < 200);
        if (!req_ready[g]) check("idle timeout", 32'd0, 32'd1);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int b;
        int rv0;
        int n;

        repeat (2) @(posedge Clock);
        #1;
        chk_en = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("reset ReqReady", req_ready[0], 1'b1);
        check("reset BusReadWrite", bus_rw[0], 1'b1);
        check("reset BusClock", bus_clk[0], 1'b0);
        check("reset RspData", rsp_data[0], 8'h00);
        check("reset BusAddress", bus_addr[0], 16'h0000);

        // Single write: one rise, ReqReady low 6 cycles.
        b = rise_q.size();
        do_req(0, 1'b1, 16'h0010, 8'h40);
        wait_idle(0);
        check("write rises", rise_q.size() - b, 32'd1);
        check("write ReqReady low", last_lo_rdy[0], 32'd6);

        // Write then read back.
        do_req(0, 1'b1, 16'h0012, 8'h02);
        wait_idle(0);
        rv0 = rv_cnt[0];
        do_req(0, 1'b0, 16'h0012, 8'h00);
        wait_idle(0);
        check("readback RspData", rsp_data[0], 8'h02);
        check("readback RspValid pulses", rv_cnt[0] - rv0, 32'd1);

        // Unmapped read floats to the pull-up value.
        rv0 = rv_cnt[0];
        do_req(0, 1'b0, 16'h0400, 8'h00);
        wait_idle(0);
        check("unmapped RspData", rsp_data[0], 8'hFF);
        check("unmapped RspValid pulses", rv_cnt[0] - rv0, 32'd1);

        // ReqValid held across three writes.
        b = rise_q.size();
        do_req(0, 1'b1, 16'h0011, 8'h01);
        do_req(0, 1'b1, 16'h0011, 8'h02);
        do_req(0, 1'b1, 16'h0011, 8'h03);
        wait_idle(0);
        check("queued rises", rise_q.size() - b, 32'd3);
        for (int k = 0; k < 2; k++) check("queued rise gap", rise_q[b + k + 1] - rise_q[b + k], 32'd7);
        do_req(0, 1'b0, 16'h0011, 8'h00);
        wait_idle(0);
        check("last queued write", rsp_data[0], 8'h03);

        // Reset during HIGH of a read.
        rv0 = rv_cnt[0];
        do_req(0, 1'b0, 16'h0012, 8'h00);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!bus_clk[0] && n < 50);
        check("reached HIGH", bus_clk[0], 1'b1);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("abort BusClock", bus_clk[0], 1'b0);
        check("abort BusReadWrite", bus_rw[0], 1'b1);
        check("abort RspValid", rsp_valid[0], 1'b0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        check("abort ReqReady", req_ready[0], 1'b1);
        repeat (8) @(posedge Clock);
        #1;
        check("abort no RspValid", rv_cnt[0] - rv0, 32'd0);
        check("abort RspData kept", rsp_data[0], 8'h00);

        // CLK_DIV = 4 instance.
        do_req(1, 1'b1, 16'h0013, 8'h80);
        wait_idle(1);
        check("div4 write ReqReady low", last_lo_rdy[1], 32'd12);
        do_req(1, 1'b0, 16'h0013, 8'h00);
        wait_idle(1);
        check("div4 RspData", rsp_data[1], 8'h80);
        check("div4 BusClock high", last_hi_len[1], 32'd4);

        repeat (3) @(posedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
